iscas_cascade_ctr: RTL and testbench



---
 rtl/iscas_cascade_pkg.sv | 14 +
 rtl/iscas_cascade_pre.sv | 27 ++
 rtl/iscas_cascade_ctr.sv | 118 +++++++++++
 tb/tb_iscas_cascade_ctr.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iscas_cascade_pkg.sv
// Shared definitions for the cascade counter: FSM state encoding and default widths.
package iscas_cascade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int PW_DEF = 4;
    localparam int CW_DEF = 4;
    localparam int CH_DEF = 2;

endpackage

// File: rtl/iscas_cascade_pre.sv
// Prescaler: counts up to pre_div while running and flags the terminal cycle.
// Anything other than an active run holds the register at zero.
module iscas_cascade_pre #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          run,
    input  logic [PW-1:0] pre_div,
    output logic          term
);

    logic [PW-1:0] pre;

    assign term = run && (pre == pre_div);

    // Prescaler register: restart on reset, clear, idle or terminal count.
    always_ff @(posedge clk) begin
        if (rst || clr || !run || (pre == pre_div)) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/iscas_cascade_ctr.sv
// Cascade counter top: run/idle FSM, prescaled up/down counter, compare and
// per-channel change detectors. Optional macro CASCADE_ONESHOT_EN makes a
// counter wrap stop the run (RUN -> DONE) until EN is dropped and re-raised.
//
// state | meaning
// IDLE  | waiting for EN, prescaler held at zero
// RUN   | prescaler counting, counter steps on each terminal event
// DONE  | one-shot finished after a wrap, CNT held until EN drops
module iscas_cascade_ctr
    import iscas_cascade_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int CW = CW_DEF,
    parameter int CH = CH_DEF
) (
    input  logic          CK,
    input  logic          G0,
    input  logic          EN,
    input  logic          DIR,
    input  logic          CLR,
    input  logic [PW-1:0] PRE_DIV,
    input  logic [CW-1:0] CMP,
    input  logic [CH-1:0] SIG,
    output logic [CW-1:0] CNT,
    output logic          TICK,
    output logic          WRAP,
    output logic          MATCH,
    output logic [CH-1:0] CHG,
    output logic [1:0]    STATE
);

`ifdef CASCADE_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    state_t        state;
    state_t        state_nx;
    logic          run;
    logic          term;
    logic          step;
    logic          wrap_ev;
    logic [CH-1:0] sig_q;

    // Running only counts when EN is still high; dropping EN in a terminal
    // cycle therefore loses the step and clears the prescaler.
    assign run     = (state == ST_RUN) && EN;
    assign step    = term && !CLR;
    assign wrap_ev = step && (DIR ? (CNT == '0) : (&CNT));
    assign STATE   = state;

    iscas_cascade_pre #(.PW(PW)) u_pre (
        .clk     (CK),
        .rst     (G0),
        .clr     (CLR),
        .run     (run),
        .pre_div (PRE_DIV),
        .term    (term)
    );

    // FSM state register.
    always_ff @(posedge CK) begin
        if (G0) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state; the unused encoding falls back to IDLE.
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: state_nx = EN ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (!EN) begin
                    state_nx = ST_IDLE;
                end else if (ONESHOT && wrap_ev) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_DONE: state_nx = EN ? ST_DONE : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Main counter with its tick and wrap strobes; CLR overrides any step.
    always_ff @(posedge CK) begin
        if (G0 || CLR) begin
            CNT  <= '0;
            TICK <= 1'b0;
            WRAP <= 1'b0;
        end else begin
            TICK <= step;
            WRAP <= wrap_ev;
            if (step) begin
                CNT <= DIR ? (CNT - CW'(1)) : (CNT + CW'(1));
            end
        end
    end

    // Compare against the current count and per-channel edge detection.
    always_ff @(posedge CK) begin
        if (G0) begin
            MATCH <= 1'b0;
            CHG   <= '0;
            sig_q <= '0;
        end else begin
            MATCH <= (CNT == CMP);
            CHG   <= SIG ^ sig_q;
            sig_q <= SIG;
        end
    end

endmodule

// File: tb/tb_iscas_cascade_ctr.sv
// Scoreboard bench for iscas_cascade_ctr: directed scenarios followed by random
// stimulus, checked cycle by cycle against an arithmetic reference model.
module tb_iscas_cascade_ctr;

    localparam int PW = 4;
    localparam int CW = 4;
    localparam int CH = 2;
    localparam int MOD = 2 ** CW;
    localparam int PMOD = 2 ** PW;

`ifdef CASCADE_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          tick;
        logic          wrap;
        logic          match;
        logic [CH-1:0] chg;
        logic [1:0]    state;
    } obs_t;

    logic          CK = 1'b1;
    logic          G0 = 1'b1;
    logic          EN = 1'b0;
    logic          DIR = 1'b0;
    logic          CLR = 1'b0;
    logic [PW-1:0] PRE_DIV = '0;
    logic [CW-1:0] CMP = '0;
    logic [CH-1:0] SIG = '0;
    logic [CW-1:0] CNT;
    logic          TICK;
    logic          WRAP;
    logic          MATCH;
    logic [CH-1:0] CHG;
    logic [1:0]    STATE;

    iscas_cascade_ctr #(.PW(PW), .CW(CW), .CH(CH)) dut (
        .CK(CK), .G0(G0), .EN(EN), .DIR(DIR), .CLR(CLR), .PRE_DIV(PRE_DIV),
        .CMP(CMP), .SIG(SIG), .CNT(CNT), .TICK(TICK), .WRAP(WRAP),
        .MATCH(MATCH), .CHG(CHG), .STATE(STATE)
    );

    always #5 CK = ~CK;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    bit   stim_done = 1'b0;

    // Reference model: 0 idle, 1 run, 2 done.
    int m_state = 0;
    int m_pre   = 0;
    int m_cnt   = 0;
    int m_sigq  = 0;

    task automatic model(input bit g0, en, dir, clr, input int pd, cmp, sig);
        obs_t e;
        bit   active;
        bit   stepped;
        bit   wrapped;
        e = '0;
        if (g0) begin
            m_state = 0; m_pre = 0; m_cnt = 0; m_sigq = 0;
        end else begin
            e.chg   = CH'(sig ^ m_sigq);
            m_sigq  = sig;
            e.match = (m_cnt == cmp);
            active  = (m_state == 1) && en;
            stepped = active && (m_pre == pd) && !clr;
            wrapped = 1'b0;
            if (clr) begin
                m_pre = 0;
                m_cnt = 0;
            end else if (stepped) begin
                m_pre = 0;
                if (dir) begin
                    wrapped = (m_cnt == 0);
                    m_cnt = (m_cnt + MOD - 1) % MOD;
                end else begin
                    wrapped = (m_cnt == MOD - 1);
                    m_cnt = (m_cnt + 1) % MOD;
                end
            end else if (active) begin
                m_pre = (m_pre + 1) % PMOD;
            end else begin
                m_pre = 0;
            end
            e.tick = stepped;
            e.wrap = wrapped;
            if (m_state == 1)      m_state = !en ? 0 : ((ONESHOT && wrapped) ? 2 : 1);
            else if (m_state == 2) m_state = en ? 2 : 0;
            else                   m_state = en ? 1 : 0;
        end
        e.cnt   = CW'(m_cnt);
        e.state = 2'(m_state);
        sb.push_back(e);
    endtask

    task automatic drive(input bit g0, en, dir, clr, input int pd, cmp, sig);
        @(negedge CK);
        G0 = g0; EN = en; DIR = dir; CLR = clr;
        PRE_DIV = PW'(pd); CMP = CW'(cmp); SIG = CH'(sig);
        model(g0, en, dir, clr, pd, cmp, sig);
    endtask

    // Monitor: every cycle the DUT presents its registered outputs; compare
    // them against the oldest expectation.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge CK);
            #1;
            cycle++;
            if (sb.size() == 0) begin
                if (!stim_done) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty cyc=%0d: no expectation queued", cycle);
                end
            end else begin
                e = sb.pop_front();
                a = '{cnt: CNT, tick: TICK, wrap: WRAP, match: MATCH, chg: CHG, state: STATE};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got cnt=%0d tick=%b wrap=%b match=%b chg=%b state=%b exp cnt=%0d tick=%b wrap=%b match=%b chg=%b state=%b",
                             cycle, a.cnt, a.tick, a.wrap, a.match, a.chg, a.state,
                             e.cnt, e.tick, e.wrap, e.match, e.chg, e.state);
                end
            end
        end
    end

    initial begin
        bit found;

        // Reset then idle.
        repeat (2)  drive(1, 0, 0, 0, 0, 0, 0);
        repeat (10) drive(0, 0, 0, 0, 0, 0, 0);

        // Up count, PRE_DIV=2, through a full wrap.
        repeat (52) drive(0, 1, 0, 0, 2, 9, 0);

        // Back to idle and zero, then down count with compare at 14.
        repeat (2) drive(0, 0, 0, 1, 0, 14, 0);
        repeat (6) drive(0, 1, 1, 0, 0, 14, 0);

        // CLR exactly on a terminal cycle with CNT=5.
        repeat (2) drive(0, 0, 0, 1, 1, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_state == 1 && m_cnt == 5 && m_pre == 1) begin
                found = 1'b1;
                break;
            end
            drive(0, 1, 0, 0, 1, 0, 0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL clr_setup: got no terminal cycle at cnt=5, required one within 100 cycles");
        end
        drive(0, 1, 0, 1, 1, 0, 0);
        repeat (8) drive(0, 1, 0, 0, 1, 0, 0);

        // Change detectors: 00 -> 10 -> 11.
        drive(0, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 2);
        drive(0, 1, 0, 0, 1, 0, 3);
        drive(0, 1, 0, 0, 1, 0, 3);

        // Reset in the middle of a run at CNT=7.
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_state == 1 && m_cnt == 7) begin
                found = 1'b1;
                break;
            end
            drive(0, 1, 0, 0, 0, 0, 1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL g0_setup: got no run cycle at cnt=7, required one within 100 cycles");
        end
        drive(1, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);

        // Run to wrap with EN held, then drop EN and re-run.
        repeat (20) drive(0, 1, 0, 0, 0, 3, 0);
        repeat (2)  drive(0, 0, 0, 0, 0, 3, 0);
        repeat (5)  drive(0, 1, 0, 0, 0, 3, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 5) == 0 ? 1'b1 : 1'b0,
                  $urandom_range(0, 24) == 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)),
                  int'($urandom_range(0, 2 ** CH - 1)));
        end

        @(posedge CK);
        #2;
        stim_done = 1'b1;
        repeat (2) @(posedge CK);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
